// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 boot/run/readback controller and its benches.
// Holds the run-control state encoding, default widths and the HLT opcode.
package mips32_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_TO_W   = 16;

    localparam logic [5:0] OP_HLT = 6'h3f;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT      = 3'd1,
        ST_RUN       = 3'd2,
        ST_DUMP_ADDR = 3'd3,
        ST_DUMP_CAP  = 3'd4,
        ST_DUMP_OUT  = 3'd5,
        ST_DONE      = 3'd6
    } run_state_t;

    function automatic logic is_hlt(input logic [31:0] word);
        return word[31:26] == OP_HLT;
    endfunction

endpackage

// File: rtl/mips32_run_timer.sv
// Run-cycle counter: load clears the count and latches a limit, enable counts up
// with saturation, and tc flags the cycle whose increment reaches a nonzero limit.
module mips32_run_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         tc
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] limit_q;
    logic         at_max;

    assign at_max = (count == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            limit_q <= '0;
        end else if (load) begin
            count   <= '0;
            limit_q <= limit;
        end else if (en && !at_max) begin
            count <= count + CNT_ONE;
        end
    end

    // A zero limit means unlimited, so tc never fires and the count just saturates.
    assign tc = en && (limit_q != '0) && !at_max && ((count + CNT_ONE) == limit_q);

endmodule

// File: rtl/mips32_run_ctrl.sv
// Boot/run/readback sequencer for the pipelined MIPS32 core: loads memory,
// pulses core init, runs until HLT or timeout, then streams a result window out.
module mips32_run_ctrl
    import mips32_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int TO_W   = DEF_TO_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              run_start,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W-1:0] dump_len,
    input  logic [TO_W-1:0]   timeout_cycles,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              core_init,
    output logic              core_run,
    input  logic              core_halted,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              timed_out,
    output logic [TO_W-1:0]   cycle_count,
    output run_state_t        dbg_state
);

    localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    run_state_t        state, state_d;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] remaining;
    logic              idle_like;
    logic              start_ok;
    logic              ld_fire;
    logic              run_exit;
    logic              rd_fire;
    logic              timer_tc;

    // Handshakes: a word moves on a clock edge where valid and ready are both high;
    // the source holds valid and payload stable until then and never withdraws.
    assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
    assign start_ok  = idle_like && run_start;
    assign ld_ready  = idle_like && !run_start && !rst;
    assign ld_fire   = ld_valid && ld_ready;
    assign run_exit  = (state == ST_RUN) && (core_halted || timer_tc);
    assign rd_fire   = (state == ST_DUMP_OUT) && rd_ready;
    assign busy      = !idle_like;
    assign dbg_state = state;

    mips32_run_timer #(
        .W(TO_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (start_ok),
        .en   (state == ST_RUN),
        .limit(timeout_cycles),
        .count(cycle_count),
        .tc   (timer_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        core_init = 1'b0;
        core_run  = 1'b0;
        rd_valid  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (run_start) begin
                    state_d = ST_INIT;
                end else if (ld_fire) begin
                    mem_we    = 1'b1;
                    mem_addr  = ld_addr;
                    mem_wdata = ld_data;
                end
            end
            ST_INIT: begin
                core_init = 1'b1;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                core_run = 1'b1;
                if (run_exit) begin
                    state_d = (remaining == '0) ? ST_DONE : ST_DUMP_ADDR;
                end
            end
            // Memory read data is registered, so the address leads the capture by one cycle.
            ST_DUMP_ADDR: begin
                mem_addr = ptr;
                state_d  = ST_DUMP_CAP;
            end
            ST_DUMP_CAP: begin
                state_d = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    state_d = (remaining == A_ONE) ? ST_DONE : ST_DUMP_ADDR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            remaining <= '0;
            rd_addr   <= '0;
            rd_data   <= '0;
            timed_out <= 1'b0;
        end else begin
            if (start_ok) begin
                ptr       <= dump_base;
                remaining <= dump_len;
                timed_out <= 1'b0;
            end
            // A halt in the same cycle as the limit counts as a clean finish.
            if (run_exit && timer_tc && !core_halted) begin
                timed_out <= 1'b1;
            end
            if (state == ST_DUMP_CAP) begin
                rd_data <= mem_rdata;
                rd_addr <= ptr;
            end
            if (rd_fire) begin
                ptr       <= ptr + A_ONE;
                remaining <= remaining - A_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mips32_run_ctrl.sv
// Self-checking bench for mips32_run_ctrl with a registered memory model and a
// minimal core stand-in that runs straight-line code up to its first HLT.
module tb_mips32_run_ctrl;
  import mips32_pkg::*;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int TW = 16;
  localparam int HLT_LAT = 5;
  localparam logic [DW-1:0] HLT_WORD = 32'hfc000000;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid, ld_ready;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          run_start;
  logic [AW-1:0] dump_base, dump_len;
  logic [TW-1:0] timeout_cycles;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          core_init, core_run, core_halted;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy, timed_out;
  logic [TW-1:0] cycle_count;
  run_state_t    dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  mips32_run_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TO_W(TW)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .run_start(run_start), .dump_base(dump_base), .dump_len(dump_len),
    .timeout_cycles(timeout_cycles),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_init(core_init), .core_run(core_run), .core_halted(core_halted),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .timed_out(timed_out), .cycle_count(cycle_count), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory: controller port, core result port, registered read
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          core_wr;
  logic [AW-1:0] core_wr_addr;
  logic [DW-1:0] core_wr_data;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (core_wr) mem[core_wr_addr] <= core_wr_data;
    mem_rdata <= mem[mem_addr];
  end

  // core stand-in: halts HLT_LAT cycles past the HLT word index, then stores one result
  logic          res_en;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_data;
  logic          halted_q;
  int            halt_after, run_cnt;

  function automatic int find_hlt();
    for (int i = 0; i < 16; i++)
      if (mem[i][31:26] === OP_HLT) return i + HLT_LAT;
    return 0;
  endfunction

  assign core_halted = halted_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
      run_cnt <= 0;
      halt_after <= 0;
      core_wr <= 1'b0;
      core_wr_addr <= '0;
      core_wr_data <= '0;
    end else begin
      core_wr <= 1'b0;
      if (core_init) begin
        halted_q <= 1'b0;
        run_cnt <= 0;
        halt_after <= find_hlt();
      end else if (core_run && !halted_q) begin
        run_cnt <= run_cnt + 1;
        if (halt_after != 0 && run_cnt + 1 == halt_after) begin
          halted_q <= 1'b1;
          core_wr <= res_en;
          core_wr_addr <= res_addr;
          core_wr_data <= res_data;
        end
      end
    end
  end

  // readback scoreboard and stall-stability monitor
  logic          hold_q = 1'b0;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_data;

  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (rst) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        check("rd_hold_valid", rd_valid, 1);
        check("rd_hold_addr", rd_addr, hold_addr);
        check("rd_hold_data", rd_data, hold_data);
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("rd_addr", rd_addr, e[AW+DW-1:DW]);
          check("rd_data", rd_data, e[DW-1:0]);
        end
      end
      hold_q = rd_valid && !rd_ready;
      hold_addr = rd_addr;
      hold_data = rd_data;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ld_addr = a;
    ld_data = d;
    ld_valid = 1'b1;
    #1;
    for (int i = 0; i < 100 && !ld_ready; i++) begin
      @(posedge clk);
      #2;
    end
    if (!ld_ready) begin
      check("ld_ready_timeout", ld_ready, 1);
      ld_valid = 1'b0;
      tick();
    end else begin
      check("ld_mem_we", mem_we, 1);
      check("ld_mem_addr", mem_addr, a);
      @(posedge clk);
      #1;
      ld_valid = 1'b0;
      shadow[a] = d;
    end
  endtask

  task automatic start_run(input logic [AW-1:0] base, input logic [AW-1:0] len,
                           input logic [TW-1:0] limit, input bit collide,
                           input logic [AW-1:0] caddr, input logic [DW-1:0] cdata);
    logic [AW-1:0] a;
    dump_base = base;
    dump_len = len;
    timeout_cycles = limit;
    run_start = 1'b1;
    if (collide) begin
      ld_valid = 1'b1;
      ld_addr = caddr;
      ld_data = cdata;
    end
    #1;
    if (collide) begin
      check("collide_ld_ready", ld_ready, 0);
      check("collide_mem_we", mem_we, 0);
    end
    for (int i = 0; i < int'(len); i++) begin
      a = base + AW'(i);
      exp_q.push_back({a, shadow[a]});
    end
    @(posedge clk);
    #1;
    run_start = 1'b0;
  endtask

  task automatic wait_done(input int exp_cycles, input bit exp_to, input int len, input int stall);
    int e = 1;
    int first_run = -1;
    int first_rdv = -1;
    int init_n = 0;
    int run_n = 0;
    int ready_wait = stall;
    bit done = 1'b0;
    bit we_busy = 1'b0;
    while (e < 3000 && !done) begin
      if (core_init) init_n++;
      if (core_run) begin
        run_n++;
        if (first_run < 0) first_run = e;
      end
      if (rd_valid && first_rdv < 0) first_rdv = e;
      if (busy && mem_we) we_busy = 1'b1;
      if (!busy) begin
        done = 1'b1;
      end else begin
        if (rd_valid && ready_wait > 0) begin
          rd_ready = 1'b0;
          ready_wait--;
        end else begin
          rd_ready = 1'b1;
        end
        tick();
        e++;
      end
    end
    rd_ready = 1'b1;
    check("done_timeout", done, 1);
    check("start_to_run", first_run, 2);
    check("init_pulses", init_n, 1);
    check("run_cycles", run_n, exp_cycles);
    check("mem_we_busy", we_busy, 0);
    check("cycle_count", cycle_count, exp_cycles);
    check("timed_out", timed_out, exp_to);
    check("final_state", dbg_state, ST_DONE);
    check("exp_q_empty", exp_q.size(), 0);
    if (len > 0) check("exit_to_rd_valid", first_rdv, first_run + run_n - 1 + 3);
    else check("no_rd_valid", first_rdv, -1);
  endtask

  initial begin
    logic [DW-1:0] fact;
    logic [DW-1:0] fact_prog [0:10];

    fact_prog = '{32'h280a00c8, 32'h28020001, 32'h0e94a000, 32'h21430000, 32'h0e94a000,
                  32'h14431000, 32'h2c630001, 32'h0e94a000, 32'h3460fffc, 32'h2542fffe,
                  HLT_WORD};
    for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;
    rst = 1'b1;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    run_start = 1'b0; dump_base = '0; dump_len = '0; timeout_cycles = '0;
    rd_ready = 1'b1;
    res_en = 1'b0; res_addr = '0; res_data = '0;
    tick();
    tick();

    // reset state
    check("rst_busy", busy, 0);
    check("rst_core_run", core_run, 0);
    check("rst_core_init", core_init, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_timed_out", timed_out, 0);
    check("rst_cycle_count", cycle_count, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    tick();
    check("idle_ld_ready", ld_ready, 1);

    // factorial image: result 7! written by the core at word 198
    for (int i = 0; i < 11; i++) load_word(AW'(i), fact_prog[i]);
    load_word(10'd200, 32'd7);
    load_word(10'd199, 32'd0);
    fact = 1;
    for (int k = 1; k <= 7; k++) fact = fact * DW'(k);
    res_en = 1'b1; res_addr = 10'd198; res_data = fact;
    shadow[198] = fact;
    start_run(10'd198, 10'd3, '0, 1'b0, '0, '0);
    wait_done(10 + HLT_LAT + 1, 1'b0, 3, 0);

    // reset during RUN, then rerun
    start_run(10'd198, 10'd0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) tick();
    check("pre_rst_core_run", core_run, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_core_run", core_run, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    tick();
    rst = 1'b0;
    tick();
    start_run(10'd198, 10'd3, '0, 1'b0, '0, '0);
    wait_done(10 + HLT_LAT + 1, 1'b0, 3, 0);

    // immediate HLT, no dump, with a colliding load
    res_en = 1'b0;
    load_word(10'd0, HLT_WORD);
    start_run(10'd0, 10'd0, '0, 1'b1, 10'd500, 32'h00001234);
    wait_done(HLT_LAT + 1, 1'b0, 0, 0);
    #1;
    check("collide_accept_we", mem_we, 1);
    check("collide_accept_addr", mem_addr, 500);
    check("collide_accept_data", mem_wdata, 32'h00001234);
    tick();
    ld_valid = 1'b0;
    shadow[500] = 32'h00001234;

    // infinite loop with timeout; dump reads back the collided load
    load_word(10'd0, 32'h28010001);
    load_word(10'd1, 32'h3420ffff);
    for (int i = 2; i < 16; i++) load_word(AW'(i), 32'h0);
    start_run(10'd500, 10'd1, 16'd20, 1'b0, '0, '0);
    wait_done(20, 1'b1, 1, 0);

    // halt and limit in the same cycle: halt wins
    load_word(10'd0, HLT_WORD);
    start_run(10'd0, 10'd0, TW'(HLT_LAT + 1), 1'b0, '0, '0);
    wait_done(HLT_LAT + 1, 1'b0, 0, 0);

    // wrapping window with rd_ready held low for 10 cycles
    load_word(10'd1023, 32'hdeadbeef);
    start_run(10'd1023, 10'd2, '0, 1'b0, '0, '0);
    wait_done(HLT_LAT + 1, 1'b0, 2, 10);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips32_run_ctrl.md
# mips32_run_ctrl

Single-clock boot/run/readback controller for the pipelined MIPS32 core. It streams a program and data image into the core's unified memory, then initialises the core (PC, HALTED and BRANCH_TAKEN cleared) and runs it until HLT or a cycle timeout. Afterwards it reads a configurable window of result words back out over a valid/ready stream. It sits between a host/loader interface and the core's memory and run-control pins, and replaces hand-poked memory setup with a reusable, parametrised sequencer.

## Interface
- DATA_W, 32, memory word width
- ADDR_W, 10, memory word-address width (depth 2^ADDR_W)
- TO_W, 16, width of timeout and cycle counters

- clk  in  1  single system clock
- rst  in  1  asynchronous, active-high reset
- ld_valid / ld_ready  in / out  1  load handshake
- ld_addr  in  ADDR_W  load word address
- ld_data  in  DATA_W  load word
- run_start  in  1  pulse; starts a run from IDLE or DONE
- dump_base, dump_len  in  ADDR_W  readback window, sampled on run_start
- timeout_cycles  in  TO_W  run limit, sampled on run_start; 0 means no limit
- mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  memory port, owned while core_run=0
- mem_rdata  in  DATA_W  registered read data, valid one cycle after mem_addr
- core_init  out  1  one-cycle pulse: PC=0, HALTED=0, BRANCH_TAKEN=0
- core_run  out  1  core enable
- core_halted  in  1  core HALTED flag
- rd_valid / rd_ready  out / in  1  readback handshake
- rd_addr  out  ADDR_W; rd_data  out  DATA_W  readback word and its address
- busy  out  1  state is not IDLE/DONE
- timed_out  out  1  sticky until next run_start
- cycle_count  out  TO_W  RUN cycles of the last run

## Operation
- States: IDLE, INIT, RUN, DUMP_ADDR, DUMP_CAP, DUMP_OUT, DONE.
- IDLE/DONE: ld_ready=1. Each ld_valid&ld_ready cycle drives mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data combinationally.
- run_start in IDLE/DONE takes priority over a same-cycle load: ld_ready=0 in that cycle, no write. Latch window and limit, clear cycle_count and timed_out, go to INIT.
- INIT: core_init=1 for exactly one cycle, then RUN.
- RUN: core_run=1, cycle_count increments each cycle.
  - core_halted=1 -> exit to DUMP_ADDR, or to DONE if dump_len=0.
  - cycle_count reaching timeout_cycles (nonzero) -> timed_out=1, same exit.
  - If halt and limit occur in the same cycle, halt wins: timed_out stays 0.
- DUMP_ADDR: mem_addr=ptr. DUMP_CAP: rd_data<=mem_rdata, rd_addr<=ptr. DUMP_OUT: rd_valid=1, held stable until rd_ready.
- On the DUMP_OUT handshake, ptr increments modulo 2^ADDR_W and remaining decrements. Remaining 0 -> DONE, else DUMP_ADDR.
- run_start is ignored outside IDLE/DONE.
- ld_valid outside IDLE/DONE is stalled (ld_ready=0), never dropped.

## Timing
- Reset values: state IDLE; core_run=0, core_init=0, mem_we=0, rd_valid=0, busy=0, timed_out=0, cycle_count=0. Outputs mem_addr, mem_wdata, rd_addr and rd_data are 0.
- Reset mid-run or mid-dump aborts immediately. core_run drops asynchronously. Memory contents are not touched.
- run_start to first core_run cycle: 2 clocks.
- Halt seen to first rd_valid: 3 clocks.
- Readback throughput: one word per 3 clocks when rd_ready is held high.
- cycle_count saturates at 2^TO_W-1 when there is no limit.

## Structure
- Shared package mips32_pkg holds the state enum, default DATA_W/ADDR_W, and the HLT opcode constant 6'h3f used by benches.
- One sub-module, mips32_run_timer: a load/clear/enable counter with saturation and a terminal-count flag, used for cycle_count and the timeout.

## Test plan
- Factorial test: load words 0-10 (ADDI R10,R0,200 … HLT 32'hfc000000), mem[200]=7 and mem[199]=0. Then run_start with dump_base=198, dump_len=3. Expected rd stream: (198,5040), (199,0), (200,7); timed_out=0.
- Immediate HLT at word 0 with dump_len=0: core_run high for a small fixed count, then DONE with no rd_valid.
- Infinite loop (BNEQZ back on a nonzero register) with timeout_cycles=20: cycle_count=20, timed_out=1, dump still performed.
- Hold rd_ready low for 10 cycles during a dump: rd_valid and rd_data stay stable and no word is lost. dump_base=1023 with dump_len=2 reads addresses 1023 then 0.
- run_start and ld_valid in the same cycle: no memory write, ld_ready=0, and the load word is accepted after DONE.
- Assert rst in RUN: core_run=0 immediately, state IDLE, and a rerun yields correct results.
